// File: rtl/shift_exec_stage.sv
// Shift execution stage: an 8..16-bit barrel shifter core behind valid/ready handshakes.
// Amounts 8..15 are split into 7-bit sub-passes; the result is registered with N/Z/C flags.

module shift_exec_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       shamt,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  logic [WIDTH:0] wide_s;

  // One extra guard bit carries the last bit shifted out; shamt 0 leaves it at zero.
  always_comb begin
    wide_s = {1'b0, data};
    result = data;
    cout   = 1'b0;
    case (mode)
      2'b00: begin
        wide_s = {1'b0, data} << shamt;
        result = wide_s[WIDTH-1:0];
        cout   = wide_s[WIDTH];
      end
      2'b01: begin
        wide_s = {data, 1'b0} >> shamt;
        result = wide_s[WIDTH:1];
        cout   = wide_s[0];
      end
      2'b10: begin
        wide_s = $signed({data, 1'b0}) >>> shamt;
        result = wide_s[WIDTH:1];
        cout   = wide_s[0];
      end
      default: begin
        wide_s = {1'b0, data};
        result = data;
        cout   = 1'b0;
      end
    endcase
  end

endmodule

module shift_exec_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_c,
  output logic             out_n,
  output logic             out_z
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    PASS2 = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] inter_r, inter_s;
  logic [1:0]       mode_r, mode_s;
  logic [3:0]       rem_r, rem_s;
  logic             out_valid_r, out_c_r, out_n_r, out_z_r;
  logic [WIDTH-1:0] out_data_r;

  logic [WIDTH-1:0] core_data_s, core_res_s;
  logic [2:0]       core_shamt_s;
  logic [1:0]       core_mode_s;
  logic             core_cout_s;
  logic             out_free_s, in_ready_s, accept_s, load_s;

  shift_exec_core #(.WIDTH(WIDTH)) u_core (
    .data   (core_data_s),
    .shamt  (core_shamt_s),
    .mode   (core_mode_s),
    .result (core_res_s),
    .cout   (core_cout_s)
  );

  // Core operand mux: fresh operand when idle, latched intermediate during PASS2.
  always_comb begin
    core_data_s  = in_data;
    core_mode_s  = in_mode;
    core_shamt_s = (in_shamt > 4'd7) ? 3'd7 : in_shamt[2:0];
    case (state_r)
      IDLE: begin
        core_data_s  = in_data;
        core_mode_s  = in_mode;
        core_shamt_s = (in_shamt > 4'd7) ? 3'd7 : in_shamt[2:0];
      end
      PASS2: begin
        core_data_s  = inter_r;
        core_mode_s  = mode_r;
        core_shamt_s = (rem_r > 4'd7) ? 3'd7 : rem_r[2:0];
      end
      default: begin
        core_data_s  = in_data;
        core_mode_s  = in_mode;
        core_shamt_s = 3'd0;
      end
    endcase
  end

  // Handshake, next-state and output-load decision.
  always_comb begin
    state_s    = state_r;
    inter_s    = inter_r;
    mode_s     = mode_r;
    rem_s      = rem_r;
    load_s     = 1'b0;
    out_free_s = !out_valid_r || out_ready;
    in_ready_s = !rst && (state_r == IDLE) && out_free_s;
    accept_s   = in_valid && in_ready_s;
    case (state_r)
      IDLE: begin
        if (accept_s && (in_mode != 2'b11) && (in_shamt > 4'd7)) begin
          state_s = PASS2;
          inter_s = core_res_s;
          mode_s  = in_mode;
          rem_s   = in_shamt - 4'd7;
        end else if (accept_s) begin
          load_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      PASS2: begin
        // A remainder of 8 takes one more 7-bit pass before the final one.
        if (rem_r > 4'd7) begin
          inter_s = core_res_s;
          rem_s   = rem_r - 4'd7;
        end else if (out_free_s) begin
          load_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = PASS2;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, intermediate and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      inter_r     <= {WIDTH{1'b0}};
      mode_r      <= 2'b00;
      rem_r       <= 4'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_c_r     <= 1'b0;
      out_n_r     <= 1'b0;
      out_z_r     <= 1'b1;
    end else begin
      state_r <= state_s;
      inter_r <= inter_s;
      mode_r  <= mode_s;
      rem_r   <= rem_s;
      if (load_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= core_res_s;
        out_c_r     <= core_cout_s;
        out_n_r     <= core_res_s[WIDTH-1];
        out_z_r     <= (core_res_s == {WIDTH{1'b0}});
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_c     = out_c_r;
  assign out_n     = out_n_r;
  assign out_z     = out_z_r;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Bench for shift_exec_stage: directed cases with literal expectations plus a random
// run checked every cycle against a transaction-level model of the stage.

module tb_shift_exec_stage;

  localparam int W = 8;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [3:0]   in_shamt;
  logic [1:0]   in_mode;
  logic         out_c, out_n, out_z;

  int tests = 0;
  int failed = 0;

  // model state: output register plus one pending long shift
  logic         m_ov, m_c, m_n, m_z, m_pend;
  logic [W-1:0] m_d;
  logic [W:0]   m_pend_r;
  int           m_passes;

  shift_exec_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_c(out_c), .out_n(out_n), .out_z(out_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Exact shift semantics for any amount; returns {carry, result}.
  function automatic logic [W:0] ref_shift(input logic [W-1:0] d, input int a, input logic [1:0] m);
    logic [W-1:0] r;
    logic c, sign;
    sign = d[W-1];
    r = d;
    c = 1'b0;
    case (m)
      2'b00: begin
        r = (a >= W) ? '0 : (d << a);
        c = (a == 0) ? 1'b0 : ((W - a >= 0) ? d[W-a] : 1'b0);
      end
      2'b01: begin
        r = (a >= W) ? '0 : (d >> a);
        c = (a == 0) ? 1'b0 : ((a - 1 < W) ? d[a-1] : 1'b0);
      end
      2'b10: begin
        for (int i = 0; i < W; i++) r[i] = (i + a < W) ? d[i+a] : sign;
        c = (a == 0) ? 1'b0 : ((a - 1 < W) ? d[a-1] : sign);
      end
      default: begin
        r = d;
        c = 1'b0;
      end
    endcase
    return {c, r};
  endfunction

  function automatic logic model_ready();
    return !rst && !m_pend && (!m_ov || out_ready);
  endfunction

  task automatic model_load(input logic [W:0] r);
    m_ov = 1'b1;
    m_d  = r[W-1:0];
    m_c  = r[W];
    m_n  = r[W-1];
    m_z  = (r[W-1:0] == '0);
  endtask

  // Advance the model by one clock edge using the inputs applied at that edge.
  task automatic model_step();
    logic acc, free, loaded;
    int a;
    if (rst) begin
      m_ov = 1'b0; m_d = '0; m_c = 1'b0; m_n = 1'b0; m_z = 1'b1;
      m_pend = 1'b0; m_passes = 0;
    end else begin
      acc = in_valid && model_ready();
      free = !m_ov || out_ready;
      loaded = 1'b0;
      a = int'(in_shamt);
      if (m_pend) begin
        if (m_passes > 1) m_passes--;
        else if (free) begin
          model_load(m_pend_r);
          loaded = 1'b1;
          m_pend = 1'b0;
        end
      end else if (acc) begin
        if (in_mode == 2'b11 || a <= 7) begin
          model_load(ref_shift(in_data, a, in_mode));
          loaded = 1'b1;
        end else begin
          m_pend = 1'b1;
          m_pend_r = ref_shift(in_data, a, in_mode);
          m_passes = (a == 15) ? 2 : 1;
        end
      end
      if (!loaded && out_ready) m_ov = 1'b0;
    end
  endtask

  // One clock: check in_ready for the applied inputs, clock the model, check outputs.
  task automatic cycle();
    #1;
    chk("in_ready", in_ready, model_ready());
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_d);
    chk("out_c", out_c, m_c);
    chk("out_n", out_n, m_n);
    chk("out_z", out_z, m_z);
  endtask

  task automatic do_op(input string name, input logic [W-1:0] d, input logic [3:0] a,
                       input logic [1:0] m, input logic [W-1:0] ed, input logic ec,
                       input logic en, input logic ez, input int elat);
    int lat, busy;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = d; in_shamt = a; in_mode = m;
    #1;
    chk({name, "_accept"}, in_ready, 1'b1);
    cycle();
    in_valid = 1'b0;
    in_data = ~d; in_shamt = ~a; in_mode = ~m;
    lat = 1; busy = 0;
    while (!out_valid && lat < 8) begin
      if (!in_ready) busy++;
      cycle();
      lat++;
    end
    chk({name, "_lat"}, lat, elat);
    chk({name, "_busy"}, busy, elat - 1);
    chk({name, "_data"}, out_data, ed);
    chk({name, "_c"}, out_c, ec);
    chk({name, "_n"}, out_n, en);
    chk({name, "_z"}, out_z, ez);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_shamt = 4'd0; in_mode = 2'b00;
    m_ov = 1'b0; m_d = '0; m_c = 1'b0; m_n = 1'b0; m_z = 1'b1; m_pend = 1'b0;
    m_pend_r = '0; m_passes = 0;
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_z", out_z, 1'b1);
    chk("rst_data", out_data, 8'h00);
    chk("rst_ready", in_ready, 1'b0);
    rst = 1'b0;
    cycle();

    do_op("lsl96_3", 8'h96, 4'd3, 2'b00, 8'hB0, 1'b0, 1'b1, 1'b0, 1);
    do_op("lsrC3_10", 8'hC3, 4'd10, 2'b01, 8'h00, 1'b0, 1'b0, 1'b1, 2);
    do_op("asr80_9", 8'h80, 4'd9, 2'b10, 8'hFF, 1'b1, 1'b1, 1'b0, 2);
    do_op("asr80_15", 8'h80, 4'd15, 2'b10, 8'hFF, 1'b1, 1'b1, 1'b0, 3);
    do_op("pass5A_13", 8'h5A, 4'd13, 2'b11, 8'h5A, 1'b0, 1'b0, 1'b0, 1);
    do_op("lsl00_0", 8'h00, 4'd0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 1);
    do_op("lsl01_8", 8'h01, 4'd8, 2'b00, 8'h00, 1'b1, 1'b0, 1'b1, 2);

    // back-to-back results, then a held output
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hF0; in_shamt = 4'd4; in_mode = 2'b01;
    cycle();
    in_data = 8'h01; in_shamt = 4'd7; in_mode = 2'b00;
    chk("b2b_first", out_data, 8'h0F);
    chk("b2b_first_c", out_c, 1'b0);
    cycle();
    chk("b2b_second", out_data, 8'h80);
    chk("b2b_second_v", out_valid, 1'b1);
    out_ready = 1'b0;
    in_data = 8'h33; in_shamt = 4'd1;
    #1;
    chk("hold_ready", in_ready, 1'b0);
    cycle();
    cycle();
    chk("hold_data", out_data, 8'h80);
    chk("hold_valid", out_valid, 1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();

    // reset while the long shift sits in its second pass
    in_valid = 1'b1; in_data = 8'hFF; in_shamt = 4'd12; in_mode = 2'b01;
    cycle();
    in_valid = 1'b0; rst = 1'b1;
    cycle();
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_z", out_z, 1'b1);
    rst = 1'b0;
    cycle();
    do_op("after_rst", 8'h0F, 4'd2, 2'b00, 8'h3C, 1'b0, 1'b0, 1'b0, 1);

    // randomized traffic with backpressure and occasional resets
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_data   = W'($urandom);
      in_shamt  = 4'($urandom);
      in_mode   = 2'($urandom);
      rst       = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst = 1'b0; in_valid = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
